// File: rtl/pol2rec_wind_pkg.sv
// Shared fixed-point formats, angle constants, gain constant and state encoding
// for the polar/rectangular CORDIC converters.
package pol2rec_wind_pkg;

    localparam int DATA_W   = 16;
    localparam int INT_W    = 20;
    localparam int FRAC_MOD = 10;
    localparam int FRAC_ANG = 7;

    localparam logic signed [15:0] ANG90_Q87   = 16'sd11520;
    localparam logic signed [15:0] ANG180_Q87  = 16'sd23040;
    localparam logic signed [19:0] ANG90_Q911  = 20'sd184320;
    localparam logic signed [19:0] ANG180_Q911 = 20'sd368640;

    // 1/K in Q0.16
    localparam logic [16:0] INV_K = 17'd39797;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCALE = 2'd1,
        ST_ROT   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic signed [15:0] sat16(input logic signed [20:0] v);
        logic signed [15:0] r;
        if (v > 21'sd32767) begin
            r = 16'sd32767;
        end else if (v < -21'sd32768) begin
            r = -16'sd32768;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/pol2rec_wind_atan_rom.sv
// Combinational atan(2^-i) table in Q9.11 degrees, indexed by iteration count.
module cordic_atan_rom (
    input  logic [3:0]  idx,
    output logic [19:0] atan
);

    // Table lookup
    always_comb begin
        case (idx)
            4'd0:    atan = 20'd92160;
            4'd1:    atan = 20'd54405;
            4'd2:    atan = 20'd28746;
            4'd3:    atan = 20'd14592;
            4'd4:    atan = 20'd7324;
            4'd5:    atan = 20'd3666;
            4'd6:    atan = 20'd1833;
            4'd7:    atan = 20'd917;
            4'd8:    atan = 20'd458;
            4'd9:    atan = 20'd229;
            4'd10:   atan = 20'd115;
            4'd11:   atan = 20'd57;
            4'd12:   atan = 20'd29;
            4'd13:   atan = 20'd14;
            4'd14:   atan = 20'd7;
            4'd15:   atan = 20'd4;
            default: atan = 20'd0;
        endcase
    end

endmodule

// File: rtl/pol2rec_wind.sv
// Iterative CORDIC polar-to-rectangular converter (Q5.10 magnitude, Q8.7 degrees).
// Define POL2REC_GAINCOMP_EN to add a SCALE state that removes the CORDIC gain.
module pol2rec_wind
    import pol2rec_wind_pkg::*;
#(
    parameter int ITER = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] mod,
    input  logic signed [DATA_W-1:0] angle,
    output logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] y,
    output logic                     busy,
    output logic                     done
);

    state_t                   state_r, state_nxt_s;
    logic [3:0]               cnt_r;
    logic signed [INT_W-1:0]  xr_r, yr_r, zr_r;
    logic signed [DATA_W-1:0] x_r, y_r;
    logic                     busy_r, done_r;
    logic                     load_s, busy_nxt_s, done_nxt_s, last_s;
    logic signed [DATA_W-1:0] mod_c_s, ang_c_s;
    logic signed [INT_W-1:0]  z_in_s, m4_s, x0_s, z0_s, xs_s, ys_s, atan_s;
    logic [INT_W-1:0]         atan_u_s;
    logic signed [INT_W:0]    xo_s, yo_s;
`ifdef POL2REC_GAINCOMP_EN
    logic signed [INT_W+17:0] prod_s;
    logic signed [INT_W-1:0]  scaled_s;
`endif

    cordic_atan_rom u_rom (
        .idx  (cnt_r),
        .atan (atan_u_s)
    );

    assign x      = x_r;
    assign y      = y_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign atan_s = $signed(atan_u_s);
    assign last_s = (cnt_r == 4'(ITER - 1));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
`ifdef POL2REC_GAINCOMP_EN
                    state_nxt_s = ST_SCALE;
`else
                    state_nxt_s = ST_ROT;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCALE: state_nxt_s = ST_ROT;
            ST_ROT: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ROT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs; busy/done are registered from the next state
    always_comb begin
        load_s     = (state_r == ST_IDLE) && start;
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_r == ST_DONE);
    end

    // Input clamping and quadrant pre-rotation into the +/-90 deg range
    always_comb begin
        if (mod < 16'sd0) begin
            mod_c_s = 16'sd0;
        end else begin
            mod_c_s = mod;
        end
        if (angle > ANG180_Q87) begin
            ang_c_s = ANG180_Q87;
        end else if (angle < -ANG180_Q87) begin
            ang_c_s = -ANG180_Q87;
        end else begin
            ang_c_s = angle;
        end
        z_in_s = {ang_c_s, 4'b0000};
        m4_s   = {2'b00, mod_c_s, 2'b00};
        if (ang_c_s > ANG90_Q87) begin
            x0_s = -m4_s;
            z0_s = z_in_s - ANG180_Q911;
        end else if (ang_c_s < -ANG90_Q87) begin
            x0_s = -m4_s;
            z0_s = z_in_s + ANG180_Q911;
        end else begin
            x0_s = m4_s;
            z0_s = z_in_s;
        end
    end

    // Shifted operands and rounded (guard bits removed) results
    always_comb begin
        xs_s = xr_r >>> cnt_r;
        ys_s = yr_r >>> cnt_r;
        xo_s = {xr_r[INT_W-1], xr_r} + 21'sd2;
        yo_s = {yr_r[INT_W-1], yr_r} + 21'sd2;
`ifdef POL2REC_GAINCOMP_EN
        prod_s   = xr_r * $signed({1'b0, INV_K});
        scaled_s = prod_s[INT_W+15:16];
`endif
    end

    // CORDIC datapath: load, optional gain scaling, micro-rotations
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            xr_r  <= 20'sd0;
            yr_r  <= 20'sd0;
            zr_r  <= 20'sd0;
            cnt_r <= 4'd0;
        end else if (load_s) begin
            xr_r  <= x0_s;
            yr_r  <= 20'sd0;
            zr_r  <= z0_s;
            cnt_r <= 4'd0;
`ifdef POL2REC_GAINCOMP_EN
        end else if (state_r == ST_SCALE) begin
            xr_r  <= scaled_s;
`endif
        end else if (state_r == ST_ROT) begin
            if (!zr_r[INT_W-1]) begin
                xr_r <= xr_r - ys_s;
                yr_r <= yr_r + xs_s;
                zr_r <= zr_r - atan_s;
            end else begin
                xr_r <= xr_r + ys_s;
                yr_r <= yr_r - xs_s;
                zr_r <= zr_r + atan_s;
            end
            cnt_r <= cnt_r + 4'd1;
        end else begin
            xr_r  <= xr_r;
            yr_r  <= yr_r;
            zr_r  <= zr_r;
            cnt_r <= cnt_r;
        end
    end

    // Output registers: results captured on completion and held
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_r    <= 16'sd0;
            y_r    <= 16'sd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            if (state_r == ST_DONE) begin
                x_r <= sat16(xo_s >>> 2);
                y_r <= sat16(yo_s >>> 2);
            end else begin
                x_r <= x_r;
                y_r <= y_r;
            end
        end
    end

endmodule

// File: tb/tb_pol2rec_wind.sv
// Self-checking bench for pol2rec_wind against a real-arithmetic polar model.
module tb_pol2rec_wind;

    localparam int ITER = 16;
`ifdef POL2REC_GAINCOMP_EN
    localparam int  LAT   = ITER + 2;
    localparam real COMP  = 39797.0 / 65536.0;
    localparam int  X1024 = 1024;
    localparam int  X2263 = 1600;
    localparam int  Y5000 = 5000;
`else
    localparam int  LAT   = ITER + 1;
    localparam real COMP  = 1.0;
    localparam int  X1024 = 1686;
    localparam int  X2263 = 2635;
    localparam int  Y5000 = 8234;
`endif
    localparam real PI = 3.14159265358979;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic signed [15:0] mod = 16'sd0;
    logic signed [15:0] angle = 16'sd0;
    logic signed [15:0] x, y;
    logic busy, done;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    pol2rec_wind #(.ITER(ITER)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .mod   (mod),
        .angle (angle),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string name, input int act, input int exp, input int tol);
        n_vec++;
        if (act > exp + tol || act < exp - tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (+/-%0d) at %0t", name, act, exp, tol, $time);
        end
    endtask

    function automatic real kgain();
        real k;
        k = 1.0;
        for (int i = 0; i < ITER; i++) k = k * $sqrt(1.0 + 1.0 / (4.0 ** i));
        return k * COMP;
    endfunction

    function automatic int rsat(input real v);
        if (v >= 32767.0) return 32767;
        if (v <= -32768.0) return -32768;
        return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
    endfunction

    task automatic model(input int m, input int a, output int ex, output int ey, output int tol);
        int  mi, ai, mag;
        real th;
        mi  = (m < 0) ? 0 : m;
        ai  = (a > 23040) ? 23040 : ((a < -23040) ? -23040 : a);
        th  = $itor(ai) / 128.0 * PI / 180.0;
        ex  = rsat($itor(mi) * kgain() * $cos(th));
        ey  = rsat($itor(mi) * kgain() * $sin(th));
        mag = (ex < 0 ? -ex : ex) + (ey < 0 ? -ey : ey);
        tol = (mi == 0) ? 0 : 4 + mag / 8000;
    endtask

    // Reference model: edge count, accepted request and expected held outputs
    int ecnt = 0, acc_e = 0, done_e = 0, next_ok = 0;
    bit valid = 1'b0;
    int ex_m = 0, ey_m = 0, tol_m = 0;
    int hx = 0, hy = 0, htol = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid   = 1'b0;
            next_ok = 0;
            hx      = 0;
            hy      = 0;
            htol    = 0;
        end else begin
            ecnt++;
            if (valid && ecnt == done_e) begin
                hx   = ex_m;
                hy   = ey_m;
                htol = tol_m;
            end
            if (start && ecnt >= next_ok) begin
                acc_e   = ecnt;
                done_e  = ecnt + LAT;
                next_ok = done_e + 1;
                valid   = 1'b1;
                model(int'(mod), int'(angle), ex_m, ey_m, tol_m);
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin : mon
        int eb, ed;
        eb = (valid && ecnt >= acc_e && ecnt < done_e) ? 1 : 0;
        ed = (valid && ecnt == done_e) ? 1 : 0;
        chk("busy", int'(busy), eb, 0);
        chk("done", int'(done), ed, 0);
        chk("x", int'(x), hx, htol);
        chk("y", int'(y), hy, htol);
    end

    task automatic issue(input int m, input int a);
        mod   = 16'(m);
        angle = 16'(a);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < LAT + 40) begin
            @(negedge clock);
            lat++;
        end
        if (!done) chk("done_timeout", int'(done), 1, 0);
    endtask

    task automatic count_done(input int cycles, output int nd);
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (done) nd++;
        end
    endtask

    initial begin
        int ex, ey, t, lat, nd, m, a, r;

        model(1024, 0, ex, ey, t);
        chk("model_1024_0_x", ex, X1024, 0);
        chk("model_1024_0_y", ey, 0, 0);
        model(2263, 5760, ex, ey, t);
        chk("model_45deg_x", ex, X2263, 0);
        model(5000, 11520, ex, ey, t);
        chk("model_90deg_y", ey, Y5000, 0);
        model(1024, 23100, ex, ey, t);
        chk("model_sat_x", ex, -X1024, 0);
        model(-500, 3000, ex, ey, t);
        chk("model_neg_tol", t, 0, 0);

        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        issue(1024, 0);
        wait_done(lat);
        chk("latency", lat, LAT, 0);
        chk("x_1024_0", int'(x), X1024, 3);
        chk("y_1024_0", int'(y), 0, 3);

        issue(2263, 5760);
        wait_done(lat);
        chk("x_45deg", int'(x), X2263, 4);
        chk("y_45deg", int'(y), X2263, 4);

        issue(5000, 11520);
        wait_done(lat);
        chk("x_90deg", int'(x), 0, 4);
        chk("y_90deg", int'(y), Y5000, 5);

        issue(1024, 23040);
        wait_done(lat);
        chk("x_180deg", int'(x), -X1024, 3);
        issue(1024, 23100);
        wait_done(lat);
        chk("x_sat_angle", int'(x), -X1024, 3);
        chk("y_sat_angle", int'(y), 0, 3);
        issue(1024, -23040);
        wait_done(lat);
        chk("x_m180deg", int'(x), -X1024, 3);

        issue(-500, 3000);
        wait_done(lat);
        chk("x_neg_mod", int'(x), 0, 0);
        chk("y_neg_mod", int'(y), 0, 0);

        // A second start while busy must be ignored
        issue(3000, 2000);
        repeat (3) @(negedge clock);
        issue(777, -4000);
        wait_done(lat);
        count_done(LAT + 4, nd);
        chk("extra_done", nd, 0, 0);

        // Abort mid-rotation
        issue(4000, 7000);
        repeat (5) @(negedge clock);
        chk("busy_before_reset", int'(busy), 1, 0);
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0, 0);
        chk("rst_done", int'(done), 0, 0);
        chk("rst_x", int'(x), 0, 0);
        chk("rst_y", int'(y), 0, 0);
        @(negedge clock);
        reset = 1'b1;
        count_done(LAT + 3, nd);
        chk("aborted_done", nd, 0, 0);
        issue(1024, 0);
        wait_done(lat);
        chk("latency_after_reset", lat, LAT, 0);
        chk("x_after_reset", int'(x), X1024, 3);

        for (int k = 0; k < 60; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) m = -int'($urandom_range(1, 32768));
            else if (r == 1) m = int'($urandom_range(16384, 32767));
            else m = int'($urandom_range(0, 16383));
            if ($urandom_range(0, 5) == 0) a = int'($urandom_range(0, 65535)) - 32768;
            else a = int'($urandom_range(0, 46080)) - 23040;
            issue(m, a);
            wait_done(lat);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (LAT + 3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
